// File: rtl/cpu_pkg.sv
// Shared ISA constants and the command-to-instruction encoder used by the
// instruction encoder and the control unit.
package cpu_pkg;

  typedef enum logic [2:0] {
    KIND_R    = 3'd0,
    KIND_LW   = 3'd1,
    KIND_SW   = 3'd2,
    KIND_BEQ  = 3'd3,
    KIND_ADDI = 3'd4,
    KIND_NOP  = 3'd5,
    KIND_SLL  = 3'd6,
    KIND_SRL  = 3'd7
  } cmd_kind_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLL   = 6'b000010;
  localparam logic [5:0] OP_SRL   = 6'b000011;
  localparam logic [5:0] OP_NOP   = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  function automatic enc_t encode_cmd(input logic [2:0]  kind,
                                      input logic [2:0]  alu,
                                      input logic [4:0]  rs,
                                      input logic [4:0]  rt,
                                      input logic [4:0]  rd,
                                      input logic [15:0] imm);
    enc_t       e;
    logic [5:0] funct;
    e.legal = 1'b1;
    e.word  = '0;
    funct   = '0;
    case (cmd_kind_e'(kind))
      KIND_R: begin
        case (alu)
          ALU_ADD: funct = FN_ADD;
          ALU_SUB: funct = FN_SUB;
          ALU_AND: funct = FN_AND;
          ALU_OR:  funct = FN_OR;
          ALU_SLT: funct = FN_SLT;
          default: e.legal = 1'b0;
        endcase
        e.word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      end
      KIND_LW:   e.word = {OP_LW,   rs, rt, imm};
      KIND_SW:   e.word = {OP_SW,   rs, rt, imm};
      KIND_BEQ:  e.word = {OP_BEQ,  rs, rt, imm};
      KIND_ADDI: e.word = {OP_ADDI, rs, rt, imm};
      KIND_NOP:  e.word = {OP_NOP,  26'b0};
      KIND_SLL:  e.word = {OP_SLL,  rs, rt, 11'b0, imm[4:0]};
      KIND_SRL:  e.word = {OP_SRL,  rs, rt, 11'b0, imm[4:0]};
      default:   e.word = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// DEPTH-entry synchronous FIFO holding encoded instruction words; the head
// entry is presented combinationally and stays put until popped.
module instr_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      // simultaneous push and pop leaves occupancy unchanged
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes commands into instruction words, buffers them, and tags each
// delivered word with a wrapping 8-bit instruction-memory address.
module instr_encoder
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_kind,
  input  logic [2:0]  cmd_alu,
  input  logic [4:0]  cmd_rs,
  input  logic [4:0]  cmd_rt,
  input  logic [4:0]  cmd_rd,
  input  logic [15:0] cmd_imm,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_word,
  output logic [7:0]  instr_addr,
  output logic        err
);

  enc_t       enc;
  logic       fifo_full;
  logic       fifo_empty;
  logic       accept;
  logic       push;
  logic       pop;
  logic [7:0] addr_q;
  logic       err_q;

  always_comb begin
    enc = encode_cmd(cmd_kind, cmd_alu, cmd_rs, cmd_rt, cmd_rd, cmd_imm);
  end

  // both handshakes are blocked while reset is high
  assign cmd_ready   = !fifo_full && !reset;
  assign instr_valid = !fifo_empty && !reset;
  assign accept      = cmd_valid && cmd_ready;
  assign push        = accept && enc.legal;
  assign pop         = instr_valid && instr_ready;
  assign instr_addr  = addr_q;
  assign err         = err_q;

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (enc.word),
    .pop       (pop),
    .pop_data  (instr_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (pop) begin
        addr_q <= addr_q + 8'd1;
      end
      if (accept && !enc.legal) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: cmd_valid  input  1  command present.
REQ-004 SHALL have port: cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a clk edge.
REQ-005 SHALL have port: cmd_kind  input  3  0 R-type, 1 lw, 2 sw, 3 beq, 4 addi, 5 nop, 6 sll, 7 srl.
REQ-006 SHALL have port: cmd_alu  input  3  R-type ALU code: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-007 SHALL have ports: cmd_rs, cmd_rt, cmd_rd  input  5 each  register fields.
REQ-008 SHALL have port: cmd_imm  input  16  immediate, or shift amount in bits [4:0].
REQ-009 SHALL have port: instr_valid  output  1  encoded word available.
REQ-010 SHALL have port: instr_ready  input  1  downstream (imem writer) accepts the word.
REQ-011 SHALL have port: instr_word  output  32  encoded instruction.
REQ-012 SHALL have port: instr_addr  output  8  imem word address of instr_word.
REQ-013 SHALL have port: err  output  1  sticky illegal-command flag.
REQ-014 SHALL have parameter: DEPTH, default 2, output buffer entries.

Function
REQ-015 SHALL encode R-type as op 000000, rs, rt, rd, shamt 00000, funct 100000/100010/100100/100101/101010 for add/sub/and/or/slt.
REQ-016 SHALL encode lw/sw/beq/addi as op 100011/101011/000100/001000, then rs, rt, imm[15:0].
REQ-017 SHALL encode sll as op 000010 and srl as op 000011, then rs, rt, {11'b0, imm[4:0]}.
REQ-018 SHALL encode nop as op 111111 with bits [25:0] all zero.
REQ-019 SHALL treat an R-type command with cmd_alu in {011, 100, 101} as illegal: consume it, emit no word, and set err, which holds until reset.
REQ-020 SHALL register the encoded word into the output buffer; an accepted command at edge N makes instr_valid high after edge N+1's sampling point, giving 1-cycle latency.
REQ-021 SHALL drive cmd_ready high whenever the buffer is not full, independent of instr_ready (no combinational ready path).
REQ-022 SHALL hold instr_word and instr_addr stable while instr_valid is high and instr_ready is low.
REQ-023 SHALL present buffered words in acceptance order.
REQ-024 SHALL, on a simultaneous push and pop, leave occupancy unchanged, and SHALL NOT drop or duplicate a word.
REQ-025 SHALL increment instr_addr by 1 on each output handshake, wrapping 255 to 0 without any flag.
REQ-026 SHALL ignore cmd_* fields while cmd_valid is low.

Reset
REQ-027 SHALL, at a reset edge, force buffer empty, instr_valid 0, instr_addr 0, err 0, and cmd_ready 1 from the following cycle.
REQ-028 SHALL discard buffered words when reset is asserted mid-stream, and SHALL NOT perform any handshake in a reset cycle.

Structure
REQ-029 SHALL take opcode constants, funct constants, cmd_kind codes and ALU codes from shared package cpu_pkg, which the control unit also uses.
REQ-030 SHALL implement buffering in one sub-module, instr_fifo, a DEPTH-entry synchronous FIFO carrying {addr-less word}; address generation SHALL stay in instr_encoder.

Verification
REQ-031 SHALL cover: lw rs=2 rt=3 imm=0x0010 -> instr_word 0x8C430010, instr_addr 0.
REQ-032 SHALL cover: R-type sub rs=1 rt=2 rd=3 -> 0x00221822; then slt same fields -> 0x0022182A, instr_addr 1.
REQ-033 SHALL cover: nop, then sll rs=0 rt=5 imm=4, then srl -> 0xFC000000, 0x08050004, 0x0C050004.
REQ-034 SHALL cover: instr_ready held low, with 3 commands offered -> cmd_ready low after 2 accepted, and the 3rd delivered in order after instr_ready rises.
REQ-035 SHALL cover: R-type cmd_alu=011 -> no instr_valid and err=1; a subsequent legal beq rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF, with instr_addr not advanced by the illegal command.
REQ-036 SHALL cover: 257 handshakes -> instr_addr wraps to 0, then reads 0; reset with 2 words buffered -> instr_valid 0 the next cycle.
